// File: rtl/leitor_lcd.sv
// -----------------------------------------------------------------------------
// leitor_lcd
// Reads N_BYTES characters back from an HD44780-compatible LCD DDRAM, starting
// at a requested address, and packs them into one wide word (first byte in the
// MSBs). Every bus access is preceded by busy-flag polling.
//
// Ports
//   Clock        in   system clock
//   Reset        in   synchronous, active-high reset
//   Inicializado in   LCD init complete; requests ignored while 0
//   Iniciar      in   single-cycle request strobe
//   Endereco     in   DDRAM start address (7 bits)
//   Dados_in     in   LCD data bus, read side
//   Enable       out  LCD E
//   RS           out  LCD RS
//   RW           out  LCD R/W (1 = read)
//   Dados_out    out  LCD data bus, write side
//   Dados_oe     out  1 = block drives the LCD data bus
//   Saida        out  bytes read, first byte in the MSBs
//   Valido       out  Saida holds the result of the last successful request
//   Ocupado      out  request in progress
//   Erro         out  last request aborted on busy timeout
// -----------------------------------------------------------------------------
module leitor_lcd #(
  parameter int N_BYTES  = 9,
  parameter int T_AS     = 2,
  parameter int T_PW     = 25,
  parameter int T_CYC    = 50,
  parameter int BUSY_MAX = 4000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Inicializado,
  input  logic                   Iniciar,
  input  logic [6:0]             Endereco,
  input  logic [7:0]             Dados_in,
  output logic                   Enable,
  output logic                   RS,
  output logic                   RW,
  output logic [7:0]             Dados_out,
  output logic                   Dados_oe,
  output logic [8*N_BYTES-1:0]   Saida,
  output logic                   Valido,
  output logic                   Ocupado,
  output logic                   Erro
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX   = (T_MAX_A > T_CYC) ? T_MAX_A : T_CYC;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int POLL_W  = $clog2(BUSY_MAX + 1);
  localparam int BYTE_W  = $clog2(N_BYTES + 1);
  localparam int SEL_W   = $clog2(8 * N_BYTES);

  localparam logic [CNT_W-1:0]  AS_LAST   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0]  PW_LAST   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(T_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(BUSY_MAX - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

  // Bus pulse phases plus the one-cycle result hand-off.
  typedef enum logic [2:0] {
    S_IDLE,
    S_AS,
    S_PW,
    S_CYC,
    S_DONE
  } state_t;

  // Kind of access carried by the current pulse.
  typedef enum logic [1:0] {
    A_POLL,
    A_CMD,
    A_RD
  } acc_t;

  // What to do once the current pulse has fully finished its recovery time.
  typedef enum logic [2:0] {
    N_POLL,
    N_CMD,
    N_RD,
    N_DONE,
    N_ABORT
  } step_t;

  state_t                r_state;
  acc_t                  r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [POLL_W-1:0]     r_poll;
  logic [BYTE_W-1:0]     r_byte;
  logic                  r_cmd_done;
  logic                  r_en;
  logic                  r_rs;
  logic                  r_rw;
  logic                  r_oe;
  logic [7:0]            r_dout;
  logic [8*N_BYTES-1:0]  r_saida;
  logic                  r_valido;
  logic                  r_ocup;
  logic                  r_erro;

  // Datapath registers: fully rewritten before use, so they carry no reset.
  logic [6:0]            r_addr;
  logic                  r_bf;
  logic [8*N_BYTES-1:0]  r_shadow;

  logic                  w_accept;
  logic                  w_phase_last;
  logic                  w_pw_end;
  step_t                 w_step;
  logic [SEL_W-1:0]      w_lsb;

  assign w_accept = (r_state == S_IDLE) && Iniciar && Inicializado;
  assign w_pw_end = (r_state == S_PW) && w_phase_last;

  // Byte k lands at bits [8*(N_BYTES-k)-1 -: 8], i.e. LSB at 8*(N_BYTES-1-k).
  assign w_lsb = SEL_W'(8 * (N_BYTES - 1 - int'(r_byte)));

  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      S_AS:    w_phase_last = (r_cnt == AS_LAST);
      S_PW:    w_phase_last = (r_cnt == PW_LAST);
      S_CYC:   w_phase_last = (r_cnt == CYC_LAST);
      default: w_phase_last = 1'b0;
    endcase
  end

  // Sequencing: every access is gated by a poll that saw BF=0; the first one
  // after acceptance goes to the set-address command, later ones to reads.
  always_comb begin
    w_step = N_POLL;
    case (r_acc)
      A_POLL: begin
        if (r_bf) begin
          w_step = (r_poll == POLL_LAST) ? N_ABORT : N_POLL;
        end else begin
          w_step = r_cmd_done ? N_RD : N_CMD;
        end
      end
      A_CMD:   w_step = N_POLL;
      A_RD:    w_step = (r_byte == BYTE_LAST) ? N_DONE : N_POLL;
      default: w_step = N_POLL;
    endcase
  end

  // Control FSM and bus outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_acc      <= A_POLL;
      r_cnt      <= '0;
      r_poll     <= '0;
      r_byte     <= '0;
      r_cmd_done <= 1'b0;
      r_en       <= 1'b0;
      r_rs       <= 1'b0;
      r_rw       <= 1'b0;
      r_oe       <= 1'b0;
      r_dout     <= 8'h00;
      r_saida    <= '0;
      r_valido   <= 1'b0;
      r_ocup     <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_valido   <= 1'b0;
            r_erro     <= 1'b0;
            r_ocup     <= 1'b1;
            r_poll     <= '0;
            r_byte     <= '0;
            r_cmd_done <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= A_POLL;
            r_rs       <= 1'b0;
            r_rw       <= 1'b1;
            r_oe       <= 1'b0;
            r_state    <= S_AS;
          end
        end

        S_AS: begin
          if (w_phase_last) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= S_PW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PW: begin
          if (w_phase_last) begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_state <= S_CYC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CYC: begin
          if (w_phase_last) begin
            r_cnt <= '0;
            // Bus control only moves here, at the start of the next setup
            // phase, so it is never disturbed while Enable is high.
            case (w_step)
              N_POLL: begin
                if (r_acc == A_POLL) r_poll <= r_poll + 1'b1;
                if (r_acc == A_CMD)  r_cmd_done <= 1'b1;
                if (r_acc == A_RD)   r_byte <= r_byte + 1'b1;
                r_acc   <= A_POLL;
                r_rs    <= 1'b0;
                r_rw    <= 1'b1;
                r_oe    <= 1'b0;
                r_dout  <= 8'h00;
                r_state <= S_AS;
              end
              N_CMD: begin
                r_poll  <= '0;
                r_acc   <= A_CMD;
                r_rs    <= 1'b0;
                r_rw    <= 1'b0;
                r_oe    <= 1'b1;
                r_dout  <= {1'b1, r_addr};
                r_state <= S_AS;
              end
              N_RD: begin
                r_poll  <= '0;
                r_acc   <= A_RD;
                r_rs    <= 1'b1;
                r_rw    <= 1'b1;
                r_oe    <= 1'b0;
                r_state <= S_AS;
              end
              N_DONE: begin
                r_rs    <= 1'b0;
                r_rw    <= 1'b0;
                r_oe    <= 1'b0;
                r_state <= S_DONE;
              end
              N_ABORT: begin
                // Saida is left untouched on timeout.
                r_rs     <= 1'b0;
                r_rw     <= 1'b0;
                r_oe     <= 1'b0;
                r_erro   <= 1'b1;
                r_valido <= 1'b0;
                r_ocup   <= 1'b0;
                r_state  <= S_IDLE;
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // Publish the whole word at once; Saida never shows a partial read.
          r_saida  <= r_shadow;
          r_valido <= 1'b1;
          r_ocup   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data capture: address latch and read sampling on the edge that ends the
  // last Enable-high cycle.
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_addr <= Endereco;
    end
    if (w_pw_end) begin
      r_bf <= Dados_in[7];
      if (r_acc == A_RD) begin
        r_shadow[w_lsb +: 8] <= Dados_in;
      end
    end
  end

  assign Enable    = r_en;
  assign RS        = r_rs;
  assign RW        = r_rw;
  assign Dados_out = r_dout;
  assign Dados_oe  = r_oe;
  assign Saida     = r_saida;
  assign Valido    = r_valido;
  assign Ocupado   = r_ocup;
  assign Erro      = r_erro;

endmodule

// File: doc/leitor_lcd.md
Name: leitor_lcd

Overview:
- Reads a run of N_BYTES characters back from an HD44780-compatible LCD's DDRAM, starting at a requested address.
- Packs the bytes into one wide word for the rest of the system.
- Bus counterpart of the LCD writer: drives RS/RW/Enable, issues a set-DDRAM-address command, then performs read cycles (RW=1).
- Polls the LCD busy flag before every access instead of relying on fixed long delays.

Parameters:
N_BYTES, 9, characters read per request; Saida width = 8*N_BYTES
T_AS, 2, clock cycles RS/RW are stable with Enable low before Enable rises
T_PW, 25, clock cycles Enable is held high (500 ns at 50 MHz)
T_CYC, 50, clock cycles Enable is held low after each pulse (hold/recovery)
BUSY_MAX, 4000, busy-flag polls allowed per access before timeout

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Inicializado  in  1  LCD init sequence complete; requests are ignored while 0
Iniciar  in  1  single-cycle request strobe
Endereco  in  7  DDRAM start address
Dados_in  in  8  LCD data bus, read side
Enable  out  1  LCD E
RS  out  1  LCD RS
RW  out  1  LCD R/W (1 = read)
Dados_out  out  8  LCD data bus, write side
Dados_oe  out  1  1 = block drives the LCD data bus
Saida  out  8*N_BYTES  bytes read; first byte in the MSBs
Valido  out  1  Saida holds the result of the last successful request
Ocupado  out  1  request in progress
Erro  out  1  last request aborted on busy timeout

Behaviour:
- One clock; reset is synchronous and active-high. On a Reset edge: state IDLE, Enable=0, RS=0, RW=0, Dados_out=0, Dados_oe=0, Saida=0, Valido=0, Ocupado=0, Erro=0, all counters 0.
- Reset mid-transaction aborts at once. Enable is low from the edge at which Reset is sampled.
- Accept: in IDLE with Iniciar=1 and Inicializado=1.
  - Latch Endereco.
  - Clear Valido and Erro.
  - Set Ocupado on the next cycle.
- Ignored requests: Iniciar while Ocupado=1, or while Inicializado=0, is dropped silently with no state change.
- Generic bus pulse:
  - Set RS/RW; hold Enable=0 for T_AS cycles.
  - Hold Enable=1 for T_PW cycles.
  - Hold Enable=0 for T_CYC cycles.
  - Read pulses sample Dados_in on the clock edge ending the last Enable-high cycle.
  - RS/RW/Dados_out/Dados_oe change only during the T_AS phase or in IDLE, never while Enable=1.
- Access sequence: BF_POLL, then CMD_WR, then for each byte k = 0..N_BYTES-1: BF_POLL, DATA_RD. Then DONE, then IDLE.
- BF_POLL: pulse with RS=0, RW=1, Dados_oe=0.
  - Sampled bit 7 = 1: repeat the poll and increment the poll counter.
  - Sampled bit 7 = 0: clear the poll counter and go to the next access.
  - Counter reaches BUSY_MAX with BF still 1: abort. Erro=1, Valido=0, Saida unchanged, Ocupado=0, go to IDLE.
- CMD_WR: pulse with RS=0, RW=0, Dados_oe=1, Dados_out = {1'b1, Endereco}.
  - Dados_oe drops to 0 at the end of the T_CYC phase.
  - The LCD latches on the Enable falling edge.
- DATA_RD: pulse with RS=1, RW=1, Dados_oe=0. The sampled byte goes to the shadow register bits [8*(N_BYTES-k)-1 -: 8]. The LCD auto-increments its address, so no address bookkeeping is needed here.
- Address wrap: Endereco + N_BYTES past the end of a DDRAM line is not handled. The LCD's own address wrap applies.
- DONE (one cycle): Saida <= shadow register, Valido=1, Ocupado=0. Saida never shows a partial result.
- Valido holds until the next accepted request.
- Idle bus state: Enable=0, RW=0, RS=0, Dados_oe=0.
- Dados_oe=1 and RW=1 are never both asserted.

Test Plan:
1. Assert Reset for 3 cycles mid-DATA_RD -> next cycle all outputs at reset values, Enable=0; a later request runs from scratch.
2. LCD model with BF=0 always and DDRAM 0x00.."ABCDEFGHI"; Iniciar with Endereco=0x00 -> exactly 20 Enable pulses, one write with Dados_out=0x80, Saida=0x414243444546474849, Valido=1, Erro=0. Check T_AS/T_PW/T_CYC cycle counts on every pulse.
3. Model holds BF=1 for 3 polls before the byte 5 read -> 23 Enable pulses, same Saida, Valido=1.
4. BF stuck at 1 after CMD_WR -> Erro=1 after exactly BUSY_MAX polls, Valido=0, Saida keeps its previous value, Ocupado=0.
5. Iniciar pulsed during a transaction, and Iniciar with Inicializado=0 -> no extra pulses, no state change.
6. Endereco=0x40 -> command byte 0xC0. Throughout the run, assert Dados_oe=1 never overlaps RW=1 and RS/RW are stable whenever Enable=1.
